// File: rtl/team_06_ptt_ctrl.sv
// Walkie-talkie talk/listen controller: debounced buttons, mute/gate/effect toggles,
// and a LIST/TALK/HANG state machine driven by PTT, a noise gate and speaker activity.
module team_06_ptt_ctrl #(
  parameter int  AUD_W       = 8,
  parameter int  N_EFFECTS   = 5,
  parameter int  DEB_CYCLES  = 1000,
  parameter int  HANG_CYCLES = 4800,
  parameter int  SPK_SQ      = 2,
  localparam int EFF_W       = $clog2(N_EFFECTS)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [AUD_W-1:0] mic_aud,
  input  logic [AUD_W-1:0] spk_aud,
  input  logic [AUD_W-2:0] threshold,
  input  logic             ptt_btn,
  input  logic             ng_btn,
  input  logic             mute_btn,
  input  logic             effect_btn,
  output logic [1:0]       state,
  output logic             talk,
  output logic             vol_en,
  output logic             effect_en,
  output logic [EFF_W-1:0] current_effect,
  output logic             mute_tog,
  output logic             noise_gate_tog
);

  localparam int             NB     = 4;
  localparam int             DEB_W  = $clog2(DEB_CYCLES) + 1;
  localparam int             HANG_W = $clog2(HANG_CYCLES) + 1;
  localparam logic [AUD_W:0] MID    = (AUD_W+1)'(1) << (AUD_W-1);

  typedef enum logic [1:0] {LIST = 2'd0, TALK = 2'd1, HANG = 2'd2} state_t;

  // Button bit order: 0 ptt, 1 noise gate, 2 mute, 3 effect.
  logic [NB-1:0]    raw, sync1, sync2, db, deb_done, press;
  logic [DEB_W-1:0] deb_cnt [NB];

  assign raw = {effect_btn, mute_btn, ng_btn, ptt_btn};

  always_comb begin
    deb_done = '0;
    press    = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      deb_done[i] = (sync2[i] != db[i]) && (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1));
      press[i]    = deb_done[i] && sync2[i];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      for (int unsigned i = 0; i < NB; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < NB; i++) begin
        if (sync2[i] == db[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_done[i]) begin
          db[i]      <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // One extra bit keeps MID +/- threshold and the speaker deviation overflow-free.
  logic [AUD_W:0] mic_x, spk_x, thr_x, spk_dev;
  logic           check, spk_active, gate_open, talk_req;

  always_comb begin
    mic_x      = {1'b0, mic_aud};
    spk_x      = {1'b0, spk_aud};
    thr_x      = {2'b00, threshold};
    check      = (mic_x >= MID + thr_x) || (mic_x <= MID - thr_x);
    spk_dev    = (spk_x >= MID) ? (spk_x - MID) : (MID - spk_x);
    spk_active = spk_dev > (AUD_W+1)'(SPK_SQ);
    gate_open  = noise_gate_tog && check;
    talk_req   = db[0] || gate_open;
  end

  state_t            st;
  logic [HANG_W-1:0] hang_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st             <= LIST;
      hang_cnt       <= '0;
      mute_tog       <= 1'b0;
      noise_gate_tog <= 1'b0;
      current_effect <= '0;
    end else begin
      case (st)
        LIST: begin
          if (!spk_active && talk_req) st <= TALK;
        end
        TALK: begin
          if (spk_active) begin
            st <= LIST;
          end else if (talk_req) begin
            st <= TALK;
          end else if (noise_gate_tog) begin
            st       <= HANG;
            hang_cnt <= HANG_W'(HANG_CYCLES - 1);
          end else begin
            st <= LIST;
          end
        end
        HANG: begin
          if (spk_active) begin
            st <= LIST;
          end else if (talk_req) begin
            st <= TALK;
          end else if (!noise_gate_tog || hang_cnt == '0) begin
            st <= LIST;
          end else begin
            hang_cnt <= hang_cnt - 1'b1;
          end
        end
        default: st <= LIST;
      endcase

      if (press[2]) mute_tog       <= ~mute_tog;
      if (press[1]) noise_gate_tog <= ~noise_gate_tog;
      if (press[3]) begin
        current_effect <= (current_effect == EFF_W'(N_EFFECTS - 1)) ? '0
                                                                    : current_effect + 1'b1;
      end
    end
  end

  assign state     = st;
  assign talk      = (st != LIST);
  assign effect_en = (st != LIST);
  assign vol_en    = (st == LIST) && !mute_tog;

endmodule

// File: tb/tb_team_06_ptt_ctrl.sv
// Bench for team_06_ptt_ctrl: directed scenarios plus random stimulus, all checked
// against a cycle-level behavioural model of the controller.
module tb_team_06_ptt_ctrl;

  localparam int AUD_W = 8;
  localparam int N_EFF = 5;
  localparam int DEB   = 4;
  localparam int HANG  = 16;
  localparam int SQ    = 2;
  localparam int MIDV  = 128;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [7:0] mic_aud = 8'd128;
  logic [7:0] spk_aud = 8'd128;
  logic [6:0] threshold = 7'd64;
  logic       ptt_btn = 1'b0, ng_btn = 1'b0, mute_btn = 1'b0, effect_btn = 1'b0;
  logic [1:0] state;
  logic       talk, vol_en, effect_en, mute_tog, noise_gate_tog;
  logic [2:0] current_effect;
  logic [9:0] obs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  team_06_ptt_ctrl #(
    .AUD_W(AUD_W), .N_EFFECTS(N_EFF), .DEB_CYCLES(DEB), .HANG_CYCLES(HANG), .SPK_SQ(SQ)
  ) dut (
    .clk(clk), .nrst(nrst), .mic_aud(mic_aud), .spk_aud(spk_aud), .threshold(threshold),
    .ptt_btn(ptt_btn), .ng_btn(ng_btn), .mute_btn(mute_btn), .effect_btn(effect_btn),
    .state(state), .talk(talk), .vol_en(vol_en), .effect_en(effect_en),
    .current_effect(current_effect), .mute_tog(mute_tog), .noise_gate_tog(noise_gate_tog)
  );

  assign obs = {state, talk, vol_en, effect_en, current_effect, mute_tog, noise_gate_tog};

  // Reference model: raw samples pass through a two-deep pipe, a button level flips
  // once it has disagreed with the pipe output for DEB cycles in a row.
  logic [3:0] m_pipe1, m_pipe2, m_lvl;
  int         m_run [4];
  int         m_state, m_hang, m_eff;
  bit         m_mute, m_ng;

  function automatic void model_reset();
    m_pipe1 = '0; m_pipe2 = '0; m_lvl = '0;
    for (int b = 0; b < 4; b++) m_run[b] = 0;
    m_state = 0; m_hang = 0; m_eff = 0; m_mute = 0; m_ng = 0;
  endfunction

  function automatic void model_step();
    logic [3:0] raw;
    bit         chk, spk_act, req;
    int         dev, nstate;
    if (!nrst) begin
      model_reset();
      return;
    end
    raw     = {effect_btn, mute_btn, ng_btn, ptt_btn};
    chk     = (int'(mic_aud) >= MIDV + int'(threshold)) || (int'(mic_aud) <= MIDV - int'(threshold));
    dev     = int'(spk_aud) - MIDV;
    if (dev < 0) dev = -dev;
    spk_act = dev > SQ;
    req     = m_lvl[0] || (m_ng && chk);
    nstate  = m_state;
    if (spk_act) nstate = 0;
    else if (req) nstate = 1;
    else if (m_state == 1) begin
      if (m_ng) begin nstate = 2; m_hang = HANG - 1; end
      else nstate = 0;
    end else if (m_state == 2) begin
      if (!m_ng || m_hang == 0) nstate = 0;
      else m_hang = m_hang - 1;
    end
    for (int b = 0; b < 4; b++) begin
      if (m_pipe2[b] != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_lvl[b] = m_pipe2[b];
          m_run[b] = 0;
          if (m_lvl[b]) begin
            case (b)
              1: m_ng = !m_ng;
              2: m_mute = !m_mute;
              3: m_eff = (m_eff + 1) % N_EFF;
              default: ;
            endcase
          end
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_pipe2 = m_pipe1;
    m_pipe1 = raw;
    m_state = nstate;
  endfunction

  function automatic logic [9:0] exp_vec();
    return {2'(m_state), m_state != 0, (m_state == 0) && !m_mute, m_state != 0,
            3'(m_eff), m_mute, m_ng};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    model_reset();
    repeat (3) tick();
    checks++;
    if (state !== 2'd0 || vol_en !== 1'b1 || talk !== 1'b0 || current_effect !== 3'd0) begin
      errors++;
      $display("FAIL reset_hold obs=%b required state=0 talk=0 vol_en=1 effect=0", obs);
    end
    nrst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec() || state !== 2'd0 || vol_en !== 1'b1 || talk !== 1'b0 ||
          current_effect !== 3'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d obs=%b required %b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_ptt_debounce();
    ptt_btn = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (state !== 2'd0 || obs !== exp_vec()) begin
        errors++;
        $display("FAIL ptt_glitch obs=%b required %b", obs, exp_vec());
      end
    end
    ptt_btn = 1'b0;
    repeat (6) begin
      tick();
      checks++;
      if (state !== 2'd0 || obs !== exp_vec()) begin
        errors++;
        $display("FAIL ptt_glitch_after obs=%b required %b", obs, exp_vec());
      end
    end
    ptt_btn = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      checks++;
      if (state !== ((e == 7) ? 2'd1 : 2'd0) || obs !== exp_vec()) begin
        errors++;
        $display("FAIL ptt_latency edge %0d state=%0d required %0d", e, state, (e == 7) ? 1 : 0);
      end
    end
    checks++;
    if (talk !== 1'b1 || vol_en !== 1'b0 || effect_en !== 1'b1) begin
      errors++;
      $display("FAIL ptt_talk_outputs talk=%b vol_en=%b effect_en=%b required 1 0 1", talk, vol_en, effect_en);
    end
    ptt_btn = 1'b0;
    repeat (8) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL ptt_release obs=%b required %b", obs, exp_vec());
      end
    end
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL ptt_back_to_list state=%0d required 0", state);
    end
  endtask

  task automatic press_ng();
    ng_btn = 1'b1;
    repeat (7) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL ng_press obs=%b required %b", obs, exp_vec());
      end
    end
    ng_btn = 1'b0;
    repeat (7) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL ng_release obs=%b required %b", obs, exp_vec());
      end
    end
  endtask

  task automatic test_noise_gate();
    press_ng();
    checks++;
    if (noise_gate_tog !== 1'b1 || state !== 2'd0) begin
      errors++;
      $display("FAIL ng_on tog=%b state=%0d required 1 0", noise_gate_tog, state);
    end
    mic_aud = 8'd200;
    tick();
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL ng_talk state=%0d required 1", state);
    end
    mic_aud = 8'd150;
    for (int i = 1; i <= 17; i++) begin
      tick();
      checks++;
      if (state !== ((i <= HANG) ? 2'd2 : 2'd0) || obs !== exp_vec()) begin
        errors++;
        $display("FAIL ng_hang cycle %0d state=%0d required %0d", i, state, (i <= HANG) ? 2 : 0);
      end
    end
    mic_aud = 8'd200;
    tick();
    mic_aud = 8'd150;
    tick();
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (state !== 2'd2 || obs !== exp_vec()) begin
        errors++;
        $display("FAIL ng_rehang cycle %0d state=%0d required 2", i, state);
      end
      tick();
    end
    mic_aud = 8'd50;
    tick();
    checks++;
    if (state !== 2'd1 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL ng_resume state=%0d required 1", state);
    end
    mic_aud = 8'd128;
    press_ng();
    repeat (4) tick();
    checks++;
    if (noise_gate_tog !== 1'b0 || state !== 2'd0 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL ng_off tog=%b state=%0d required 0 0", noise_gate_tog, state);
    end
  endtask

  task automatic test_speaker();
    int n;
    ptt_btn = 1'b1;
    n = 0;
    while (state !== 2'd1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL spk_wait_talk state=%0d required 1 within 20 cycles", state);
    end
    spk_aud = 8'd130;
    repeat (3) begin
      tick();
      checks++;
      if (state !== 2'd1 || obs !== exp_vec()) begin
        errors++;
        $display("FAIL spk_squelch_edge state=%0d required 1", state);
      end
    end
    spk_aud = 8'd131;
    tick();
    checks++;
    if (state !== 2'd0 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL spk_priority_hi state=%0d required 0", state);
    end
    spk_aud = 8'd128;
    tick();
    checks++;
    if (state !== 2'd1 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL spk_retalk state=%0d required 1", state);
    end
    spk_aud = 8'd125;
    tick();
    checks++;
    if (state !== 2'd0 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL spk_priority_lo state=%0d required 0", state);
    end
    spk_aud = 8'd128;
    ptt_btn = 1'b0;
    repeat (8) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL spk_release obs=%b required %b", obs, exp_vec());
      end
    end
  endtask

  task automatic test_effect_wrap();
    int seq [5] = '{1, 2, 3, 4, 0};
    int prev;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      effect_btn = 1'b1;
      for (int t = 1; t <= 6; t++) begin
        tick();
        checks++;
        if (current_effect !== 3'((t == 6) ? seq[k] : prev) || obs !== exp_vec()) begin
          errors++;
          $display("FAIL effect_step press %0d edge %0d effect=%0d required %0d",
                   k, t, current_effect, (t == 6) ? seq[k] : prev);
        end
      end
      prev = seq[k];
      effect_btn = 1'b0;
      repeat (6) tick();
    end
  endtask

  task automatic test_mute_reset();
    mute_btn = 1'b1;
    repeat (6) tick();
    checks++;
    if (vol_en !== 1'b0 || mute_tog !== 1'b1 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL mute_on vol_en=%b mute_tog=%b required 0 1", vol_en, mute_tog);
    end
    mute_btn = 1'b0;
    repeat (6) tick();
    press_ng();
    mic_aud = 8'd200;
    tick();
    mic_aud = 8'd150;
    repeat (4) tick();
    checks++;
    if (state !== 2'd2 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL mute_reach_hang state=%0d required 2", state);
    end
    #2;
    nrst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (state !== 2'd0 || mute_tog !== 1'b0 || vol_en !== 1'b1 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL async_reset state=%0d mute_tog=%b vol_en=%b required 0 0 1", state, mute_tog, vol_en);
    end
    repeat (2) tick();
    nrst = 1'b1;
    mic_aud = 8'd128;
    repeat (3) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL post_reset obs=%b required %b", obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int         hold [4] = '{0, 0, 0, 0};
    logic [3:0] lvl;
    lvl = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (hold[b] == 0) begin
          lvl[b]  = 1'($urandom_range(0, 1));
          hold[b] = int'($urandom_range(1, 12));
        end else begin
          hold[b]--;
        end
      end
      {effect_btn, mute_btn, ng_btn, ptt_btn} = lvl;
      if ($urandom_range(0, 7) == 0) mic_aud = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0)
        spk_aud = ($urandom_range(0, 3) == 0) ? 8'(124 + $urandom_range(0, 8)) : 8'd128;
      if (c % 400 == 0) threshold = 7'($urandom_range(0, 127));
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random cycle %0d obs=%b required %b", c, obs, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_ptt_debounce();
    test_noise_gate();
    test_speaker();
    test_effect_wrap();
    test_mute_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/team_06_ptt_ctrl.md
# team_06_ptt_ctrl

Parametrised talk/listen controller for the team_06 walkie-talkie audio path, between the button/audio front end and the effect, volume and transmit datapaths. Generalises the talk/listen control in width (AUD_W), effect count (N_EFFECTS) and button handling. Adds on-chip button debouncing, a programmable noise-gate threshold, and a noise-gate hang state so speech gaps do not drop the link.

## Interface
Parameters:
- AUD_W, 8: audio sample width. Samples are offset-binary with midscale MID = 2^(AUD_W-1). Must be ≥ 4.
- N_EFFECTS, 5: number of selectable effects. Must be ≥ 2. EFF_W = $clog2(N_EFFECTS).
- DEB_CYCLES, 1000: consecutive stable cycles required to accept a button level. Must be ≥ 1.
- HANG_CYCLES, 4800: noise-gate hold time in cycles after mic falls below threshold. Must be ≥ 1.
- SPK_SQ, 2: speaker squelch. The speaker counts as active when |spk_aud − MID| > SPK_SQ.

Ports:
- clk, in, 1: single clock.
- nrst, in, 1: asynchronous, active-low reset.
- mic_aud, in, AUD_W: live mic sample.
- spk_aud, in, AUD_W: live received sample.
- threshold, in, AUD_W-1: noise-gate magnitude threshold. Quasi-static.
- ptt_btn, in, 1: raw push-to-talk button, level-sensitive.
- ng_btn, in, 1: raw noise-gate button. Toggles on press.
- mute_btn, in, 1: raw mute button. Toggles on press.
- effect_btn, in, 1: raw effect-advance button.
- state, out, 2: current state (LIST=0, TALK=1, HANG=2).
- talk, out, 1: high in TALK or HANG.
- vol_en, out, 1: speaker volume enable.
- effect_en, out, 1: effect datapath enable.
- current_effect, out, EFF_W: selected effect index.
- mute_tog, out, 1: mute status.
- noise_gate_tog, out, 1: noise-gate status.

## Operation
Button conditioning (applies to all four buttons):
- Each raw button passes through a 2-flop synchroniser, then a debouncer.
- The debouncer has a DEB_CYCLES counter. Any cycle where the synchronised value equals the debounced level clears the counter; otherwise the counter increments.
- When the synchronised value has differed for DEB_CYCLES consecutive cycles, the debounced level takes the new value and the counter clears.
- A press event is a debounced 0→1 transition.
- ptt_db is the debounced PTT level.

Toggles and effect selection:
- A press on mute_btn inverts mute_tog. A press on ng_btn inverts noise_gate_tog.
- A press on effect_btn advances current_effect by 1 and wraps from N_EFFECTS−1 to 0.
- The effect can be changed in any state.

Detection (combinational, computed at AUD_W+1 bits, no overflow):
- check = (mic_aud ≥ MID + threshold) OR (mic_aud ≤ MID − threshold).
- With threshold = 0, check is always 1.
- spk_active = |spk_aud − MID| > SPK_SQ.
- gate_open = noise_gate_tog AND check.

FSM transitions (priority in the order listed):
- LIST:
  - spk_active → stay in LIST.
  - ptt_db OR gate_open → TALK.
- TALK:
  - spk_active → LIST.
  - ptt_db OR gate_open → stay in TALK.
  - noise_gate_tog with check = 0 → HANG, loading hang_cnt = HANG_CYCLES−1.
  - otherwise → LIST.
- HANG:
  - spk_active → LIST.
  - ptt_db OR gate_open → TALK.
  - noise_gate_tog = 0 → LIST.
  - hang_cnt = 0 → LIST.
  - otherwise decrement hang_cnt and stay in HANG.
- An unused state encoding goes to LIST.

Outputs (combinational from registers only):
- talk = effect_en = (state ≠ LIST).
- vol_en = (state = LIST) AND NOT mute_tog.

## Timing
- Reset (nrst low, asynchronous) forces:
  - state = LIST, talk = 0, effect_en = 0, current_effect = 0, mute_tog = 0, noise_gate_tog = 0, hang_cnt = 0.
  - vol_en = 1.
  - All synchroniser flops, debounced levels and counters = 0.
- Reset asserted mid-HANG or mid-debounce discards all progress.
- Raw button step to debounced level change: 2 + DEB_CYCLES clock edges. The toggle or effect register updates on the same edge as the debounced level.
- A glitch shorter than DEB_CYCLES synchronised cycles has no effect.
- Audio or ptt_db change to state change: 1 edge.
- HANG lasts exactly HANG_CYCLES cycles when nothing intervenes; LIST is entered on edge HANG_CYCLES after entry.
- When a PTT debounced release and spk_active occur in the same cycle, the result is LIST (same outcome either way).
- When a press event and an FSM transition occur in the same cycle, both take effect on the same edge.

## Test plan
Settings: AUD_W=8, DEB_CYCLES=4, HANG_CYCLES=16, SPK_SQ=2, threshold=64, spk_aud=128 unless stated.
- Reset and idle: hold nrst low for 3 cycles, then release. Required: state=0, vol_en=1, talk=0, current_effect=0 through 20 idle cycles.
- PTT debounce: raise ptt_btn for 3 cycles, then lower. Required: state stays LIST. Raise ptt_btn and hold. Required: state=TALK exactly 7 edges after the rise; talk=1, vol_en=0.
- Noise gate with hang:
  - Toggle the gate on (noise_gate_tog=1), set mic_aud=200. Required: TALK.
  - Set mic_aud=150. Required: HANG for 16 cycles, then LIST.
  - Repeat, returning mic_aud to 50 after 8 HANG cycles. Required: back to TALK.
- Speaker priority: in TALK under PTT, set spk_aud=131. Required: LIST next edge. With spk_aud=130, state stays TALK.
- Effect wrap: apply 5 clean effect_btn presses. Required: current_effect steps 1,2,3,4,0.
- Mute and reset mid-operation:
  - Press mute_btn in LIST. Required: vol_en=0.
  - Pulse nrst low during HANG. Required: state=LIST and mute_tog=0 immediately (asynchronously); vol_en=1.
